light_driver: RTL

LIGHT_DRIVER -- requirements
Module: light_driver

---
 rtl/light_driver_if.sv | 25 ++
 rtl/light_driver.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/light_driver_if.sv
// Signal bundle between the upstream light controller and the lamp driver.
// The controller side drives the state code and button; the driver side drives the lamps.
interface light_driver_if;
  logic       Qa;
  logic       Qb;
  logic       PED_REQ;
  logic       lamp_red;
  logic       lamp_yellow;
  logic       lamp_green;
  logic       walk;
  logic       dont_walk;
  logic       fault;
  logic [3:0] walk_cnt;
  logic [7:0] dwell;

  modport master (
    output Qa, Qb, PED_REQ,
    input  lamp_red, lamp_yellow, lamp_green, walk, dont_walk, fault, walk_cnt, dwell
  );

  modport slave (
    input  Qa, Qb, PED_REQ,
    output lamp_red, lamp_yellow, lamp_green, walk, dont_walk, fault, walk_cnt, dwell
  );
endinterface

// File: rtl/light_driver.sv
// Registered lamp driver: decodes the upstream state code, runs pedestrian WALK phases
// and latches a flashing-red FAULT after repeated illegal codes.
module light_driver #(
  parameter int unsigned WALK_TIME   = 8,
  parameter int unsigned FLASH_DIV   = 4,
  parameter int unsigned FAULT_LIMIT = 2
) (
  input  logic           CLK,
  input  logic           RES,
  light_driver_if.slave  bus
);

  localparam logic [1:0] ST_NORMAL = 2'd0;
  localparam logic [1:0] ST_WALK   = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;

  localparam logic [1:0] CODE_RED    = 2'b00;
  localparam logic [1:0] CODE_GREEN  = 2'b01;
  localparam logic [1:0] CODE_YELLOW = 2'b10;
  localparam logic [1:0] CODE_ILL    = 2'b11;

  localparam logic [3:0] WALK_INIT  = 4'(WALK_TIME);
  localparam logic [7:0] FLASH_LAST = 8'(FLASH_DIV - 1);
  localparam logic [3:0] ILL_LIMIT  = 4'(FAULT_LIMIT);

  logic [1:0] state_q,       state_d;
  logic [1:0] prev_code_q,   prev_code_d;
  logic [3:0] ill_cnt_q,     ill_cnt_d;
  logic [7:0] flash_cnt_q,   flash_cnt_d;
  logic       ped_pending_q, ped_pending_d;
  logic       lamp_red_q,    lamp_red_d;
  logic       lamp_yellow_q, lamp_yellow_d;
  logic       lamp_green_q,  lamp_green_d;
  logic       walk_q,        walk_d;
  logic       fault_q,       fault_d;
  logic [3:0] walk_cnt_q,    walk_cnt_d;
  logic [7:0] dwell_q,       dwell_d;

  logic [1:0] code;
  logic       illegal;
  logic       red_entry;
  logic       fault_hit;
  logic [3:0] ill_cnt_inc;

  // NOTE: every _d gets a default before any branch so no path leaves it unassigned (no latches).
  always_comb begin
    code        = {bus.Qa, bus.Qb};
    illegal     = (code == CODE_ILL);
    red_entry   = (code == CODE_RED) &&
                  ((prev_code_q == CODE_GREEN) || (prev_code_q == CODE_YELLOW));
    ill_cnt_inc = (ill_cnt_q == 4'hf) ? ill_cnt_q : ill_cnt_q + 4'd1;
    fault_hit   = illegal && (ill_cnt_inc >= ILL_LIMIT);

    state_d       = state_q;
    prev_code_d   = code;
    ill_cnt_d     = illegal ? ill_cnt_inc : 4'd0;
    flash_cnt_d   = flash_cnt_q;
    ped_pending_d = ped_pending_q | bus.PED_REQ;
    lamp_red_d    = lamp_red_q;
    lamp_yellow_d = lamp_yellow_q;
    lamp_green_d  = lamp_green_q;
    walk_d        = walk_q;
    fault_d       = fault_q;
    walk_cnt_d    = walk_cnt_q;
    dwell_d       = (code != prev_code_q) ? 8'd0 :
                    (dwell_q == 8'hff)    ? dwell_q : dwell_q + 8'd1;

    // An illegal code leaves the lamps showing whatever they showed last.
    if (!illegal) begin
      lamp_red_d    = (code == CODE_RED);
      lamp_yellow_d = (code == CODE_YELLOW);
      lamp_green_d  = (code == CODE_GREEN);
    end

    if (state_q == ST_FAULT) begin
      ill_cnt_d     = ill_cnt_q;
      lamp_yellow_d = 1'b0;
      lamp_green_d  = 1'b0;
      lamp_red_d    = lamp_red_q;
      walk_d        = 1'b0;
      walk_cnt_d    = 4'd0;
      fault_d       = 1'b1;
      if (flash_cnt_q >= FLASH_LAST) begin
        flash_cnt_d = 8'd0;
        lamp_red_d  = ~lamp_red_q;
      end else begin
        flash_cnt_d = flash_cnt_q + 8'd1;
      end
    end else if (fault_hit) begin
      state_d       = ST_FAULT;
      lamp_red_d    = 1'b1;
      lamp_yellow_d = 1'b0;
      lamp_green_d  = 1'b0;
      walk_d        = 1'b0;
      walk_cnt_d    = 4'd0;
      fault_d       = 1'b1;
      flash_cnt_d   = 8'd0;
    end else if (state_q == ST_WALK) begin
      // Leaving red mid-phase aborts the walk just like the normal count-out does.
      if ((code != CODE_RED) || (walk_cnt_q <= 4'd1)) begin
        state_d    = ST_NORMAL;
        walk_d     = 1'b0;
        walk_cnt_d = 4'd0;
      end else begin
        walk_cnt_d = walk_cnt_q - 4'd1;
      end
    end else begin
      state_d = ST_NORMAL;
      if (red_entry && (ped_pending_q || bus.PED_REQ)) begin
        state_d       = ST_WALK;
        walk_d        = 1'b1;
        walk_cnt_d    = WALK_INIT;
        ped_pending_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q       <= ST_NORMAL;
      prev_code_q   <= CODE_RED;
      ill_cnt_q     <= 4'd0;
      flash_cnt_q   <= 8'd0;
      ped_pending_q <= 1'b0;
      lamp_red_q    <= 1'b1;
      lamp_yellow_q <= 1'b0;
      lamp_green_q  <= 1'b0;
      walk_q        <= 1'b0;
      fault_q       <= 1'b0;
      walk_cnt_q    <= 4'd0;
      dwell_q       <= 8'd0;
    end else begin
      state_q       <= state_d;
      prev_code_q   <= prev_code_d;
      ill_cnt_q     <= ill_cnt_d;
      flash_cnt_q   <= flash_cnt_d;
      ped_pending_q <= ped_pending_d;
      lamp_red_q    <= lamp_red_d;
      lamp_yellow_q <= lamp_yellow_d;
      lamp_green_q  <= lamp_green_d;
      walk_q        <= walk_d;
      fault_q       <= fault_d;
      walk_cnt_q    <= walk_cnt_d;
      dwell_q       <= dwell_d;
    end
  end

  assign bus.lamp_red    = lamp_red_q;
  assign bus.lamp_yellow = lamp_yellow_q;
  assign bus.lamp_green  = lamp_green_q;
  assign bus.walk        = walk_q;
  assign bus.dont_walk   = ~walk_q;
  assign bus.fault       = fault_q;
  assign bus.walk_cnt    = walk_cnt_q;
  assign bus.dwell       = dwell_q;

endmodule
